// File: rtl/depth_bar_hud.sv
// depth_bar_hud: depth-bar HUD sprite for the hole-in-the-wall game.
// Draws a horizontal bar with a wall marker, up to NUM_PLAYERS player markers and the two
// goal-window bounds. Depths are captured once per frame on the latch line, player markers
// slew toward their targets by at most SLEW per frame, and in-goal players blink.
//
// Ports:
//   clk_in            pixel clock
//   rst_in            synchronous active-high reset
//   hcount_in         horizontal pixel count (11 bits)
//   vcount_in         vertical line count (10 bits)
//   wall_depth_in     wall depth target
//   player_depths_in  packed player depth targets, player i at [8i+7:8i]
//   num_players_in    number of active players, clamped to NUM_PLAYERS
//   pixel_out         RGB pixel, two cycles after hcount/vcount
//   in_sprite         pixel-inside-sprite flag, aligned with pixel_out
module depth_bar_hud #(
  parameter int unsigned NUM_PLAYERS  = 4,
  parameter int unsigned MAX_DEPTH    = 75,
  parameter int unsigned GOAL_DEPTH   = 60,
  parameter int unsigned GOAL_DELTA   = 10,
  parameter int unsigned X            = 800,
  parameter int unsigned Y            = 100,
  parameter int unsigned SCALE_SHIFT  = 2,
  parameter int unsigned WIDTH        = (MAX_DEPTH + 1) << SCALE_SHIFT,
  parameter int unsigned HEIGHT       = 20,
  parameter int unsigned LATCH_V      = 720,
  parameter int unsigned SLEW         = 4,
  parameter int unsigned BLINK_FRAMES = 15,
  parameter logic [23:0] WALL_COLOR   = 24'hFF0080,
  parameter logic [23:0] GOAL_COLOR   = 24'h000080,
  parameter logic [23:0] BG_COLOR     = 24'hFFFFFF,
  parameter logic [23:0] BLINK_COLOR  = 24'hFFD700,
  parameter logic [NUM_PLAYERS*24-1:0] PLAYER_COLORS = (NUM_PLAYERS*24)'({
    24'h8000FF, 24'hFF8000, 24'h808080, 24'hFF00FF,
    24'h00FFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000})
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [10:0]                          hcount_in,
  input  logic [9:0]                           vcount_in,
  input  logic [7:0]                           wall_depth_in,
  input  logic [8*NUM_PLAYERS-1:0]             player_depths_in,
  input  logic [$clog2(NUM_PLAYERS+1)-1:0]     num_players_in,
  output logic [23:0]                          pixel_out,
  output logic                                 in_sprite
);

  localparam int unsigned NPW = $clog2(NUM_PLAYERS + 1);
  localparam int unsigned FCW = $clog2(BLINK_FRAMES + 1);

  localparam logic [7:0]           MAX_D   = 8'(MAX_DEPTH);
  localparam logic [7:0]           GOAL_LO = 8'(GOAL_DEPTH - GOAL_DELTA);
  localparam logic [7:0]           GOAL_HI = 8'(GOAL_DEPTH + GOAL_DELTA);
  localparam logic [10:0]          X_LO    = 11'(X);
  localparam logic [10:0]          X_HI    = 11'(X + WIDTH);
  localparam logic [9:0]           Y_LO    = 10'(Y);
  localparam logic [9:0]           Y_HI    = 10'(Y + HEIGHT);
  localparam logic [9:0]           LATCH_L = 10'(LATCH_V);
  localparam logic signed [8:0]    SLEW_S  = 9'(SLEW);
  localparam logic [NPW-1:0]       NP_CAP  = NPW'(NUM_PLAYERS);

  function automatic logic [7:0] clamp_depth(input logic [7:0] d);
    return (d > MAX_D) ? MAX_D : d;
  endfunction

  // Step cur toward tgt by at most SLEW; both stay in 0..MAX_DEPTH so the result does too.
  function automatic logic [7:0] slew_step(input logic [7:0] cur, input logic [7:0] tgt);
    logic signed [8:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > SLEW_S) begin
      return cur + 8'(SLEW);
    end else if (diff < -SLEW_S) begin
      return cur - 8'(SLEW);
    end
    return tgt;
  endfunction

  logic                 tick;
  logic [7:0]           wall_q;
  logic [7:0]           player_q [NUM_PLAYERS];
  logic [NPW-1:0]       num_active_q;
  logic [FCW-1:0]       frame_cnt_q;
  logic                 phase_q;
  logic                 primed_q;

  assign tick = (hcount_in == 11'd0) && (vcount_in == LATCH_L);

  // Targets are consumed on the same edge they are captured, so the displayed registers are
  // the only per-frame state; the wall displayed depth is its target.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wall_q       <= '0;
      for (int i = 0; i < int'(NUM_PLAYERS); i++) player_q[i] <= '0;
      num_active_q <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
      primed_q     <= 1'b0;
    end else if (tick) begin
      wall_q <= clamp_depth(wall_depth_in);
      for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
        player_q[i] <= primed_q ? slew_step(player_q[i], clamp_depth(player_depths_in[8*i +: 8]))
                                : clamp_depth(player_depths_in[8*i +: 8]);
      end
      num_active_q <= (num_players_in > NP_CAP) ? NP_CAP : num_players_in;
      if (frame_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
        frame_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      primed_q <= 1'b1;
    end
  end

  // Stage 1: sprite hit test and depth column.
  logic        s1_in_d, s1_in_q;
  logic [10:0] h_off;
  logic [7:0]  s1_depth_d, s1_depth_q;

  always_comb begin
    s1_in_d    = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                 (vcount_in >= Y_LO) && (vcount_in < Y_HI);
    h_off      = hcount_in - X_LO;
    s1_depth_d = s1_in_d ? 8'(h_off >> SCALE_SHIFT) : 8'd0;
  end

  // Stage 2: colour priority. Later assignments win, and the player loop runs from the top
  // index down so the lowest matching index takes the pixel.
  logic [23:0] color_d;

  always_comb begin
    color_d = BG_COLOR;
    if ((s1_depth_q == GOAL_LO) || (s1_depth_q == GOAL_HI)) color_d = GOAL_COLOR;
    for (int i = int'(NUM_PLAYERS) - 1; i >= 0; i--) begin
      if ((NPW'(i) < num_active_q) && (player_q[i] == s1_depth_q)) begin
        if (phase_q && (player_q[i] >= GOAL_LO) && (player_q[i] <= GOAL_HI)) begin
          color_d = BLINK_COLOR;
        end else begin
          color_d = PLAYER_COLORS[24*i +: 24];
        end
      end
    end
    if (s1_depth_q == wall_q) color_d = WALL_COLOR;
    if (!s1_in_q) color_d = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_in_q    <= 1'b0;
      s1_depth_q <= '0;
      pixel_out  <= '0;
      in_sprite  <= 1'b0;
    end else begin
      s1_in_q    <= s1_in_d;
      s1_depth_q <= s1_depth_d;
      pixel_out  <= color_d;
      in_sprite  <= s1_in_q;
    end
  end

endmodule

// File: tb/tb_depth_bar_hud.sv
module tb_depth_bar_hud;

  localparam int X = 800;
  localparam int Y = 100;
  localparam int W = 304;
  localparam int H = 20;
  localparam logic [23:0] WALL  = 24'hFF0080;
  localparam logic [23:0] GOAL  = 24'h000080;
  localparam logic [23:0] BG    = 24'hFFFFFF;
  localparam logic [23:0] BLINK = 24'hFFD700;
  localparam logic [95:0] PAL   = {24'h00FFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000};

  logic [23:0] pal [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h00FFFF};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount = 11'd5;
  logic [9:0]  vcount = 10'd5;
  logic [7:0]  wall_depth = '0;
  logic [31:0] player_depths = '0;
  logic [2:0]  num_players = '0;
  logic [23:0] pixel_out;
  logic        in_sprite;

  int total = 0;
  int bad   = 0;

  // Reference model state, in plain integers.
  int m_wall, m_na, m_cnt, m_phase, m_primed;
  int m_p [4];

  always #5 clk = ~clk;

  depth_bar_hud #(.PLAYER_COLORS(PAL)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .hcount_in       (hcount),
    .vcount_in       (vcount),
    .wall_depth_in   (wall_depth),
    .player_depths_in(player_depths),
    .num_players_in  (num_players),
    .pixel_out       (pixel_out),
    .in_sprite       (in_sprite)
  );

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_wall = 0; m_na = 0; m_cnt = 0; m_phase = 0; m_primed = 0;
    for (int i = 0; i < 4; i++) m_p[i] = 0;
  endfunction

  function automatic int clampi(input int d);
    return (d > 75) ? 75 : d;
  endfunction

  function automatic void model_tick(input int w, input logic [31:0] pd, input int n);
    int t;
    m_wall = clampi(w);
    for (int i = 0; i < 4; i++) begin
      t = clampi(int'(pd[8*i +: 8]));
      if (m_primed == 0 || (t - m_p[i] <= 4 && m_p[i] - t <= 4)) m_p[i] = t;
      else if (t > m_p[i]) m_p[i] = m_p[i] + 4;
      else m_p[i] = m_p[i] - 4;
    end
    m_na = (n > 4) ? 4 : n;
    if (m_cnt == 14) begin
      m_cnt = 0;
      m_phase = 1 - m_phase;
    end else begin
      m_cnt++;
    end
    m_primed = 1;
  endfunction

  function automatic logic inside_sprite(input int h, input int v);
    return (h >= X && h < X + W && v >= Y && v < Y + H);
  endfunction

  function automatic logic [23:0] exp_pix(input int h, input int v);
    int d;
    if (!inside_sprite(h, v)) return 24'h0;
    d = (h - X) / 4;
    if (d == m_wall) return WALL;
    for (int i = 0; i < m_na; i++) begin
      if (m_p[i] == d) return (m_phase == 1 && m_p[i] >= 50 && m_p[i] <= 70) ? BLINK : pal[i];
    end
    if (d == 50 || d == 70) return GOAL;
    return BG;
  endfunction

  task automatic do_tick(input int w, input logic [31:0] pd, input int n);
    @(negedge clk);
    hcount = 11'd0; vcount = 10'd720;
    wall_depth = 8'(w); player_depths = pd; num_players = 3'(n);
    model_tick(w, pd, n);
    @(negedge clk);
    // Off the tick cycle the depth inputs must not matter.
    hcount = 11'd5; vcount = 10'd5;
    wall_depth = 8'($urandom); player_depths = $urandom; num_players = 3'($urandom);
  endtask

  task automatic probe_exp(input string tag, input int h, input int v, input logic [23:0] ep);
    @(negedge clk);
    hcount = 11'(h); vcount = 10'(v);
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("%s pix h=%0d v=%0d", tag, h, v), pixel_out, ep);
    chk($sformatf("%s ins h=%0d v=%0d", tag, h, v), {23'b0, in_sprite},
        {23'b0, inside_sprite(h, v)});
  endtask

  task automatic probe(input string tag, input int h, input int v);
    probe_exp(tag, h, v, exp_pix(h, v));
  endtask

  task automatic scan(input string tag);
    for (int d = 0; d < 76; d++) begin
      probe(tag, X + d * 4 + int'($urandom_range(0, 3)), Y + int'($urandom_range(0, H - 1)));
    end
  endtask

  task automatic do_reset(input int h, input int v);
    @(negedge clk);
    rst = 1'b1; hcount = 11'(h); vcount = 10'(v);
    @(negedge clk);
    chk("reset pix", pixel_out, 24'h0);
    chk("reset ins", {23'b0, in_sprite}, 24'h0);
    @(negedge clk);
    chk("reset pix2", pixel_out, 24'h0);
    rst = 1'b0; hcount = 11'd5; vcount = 10'd5;
    model_reset();
  endtask

  int slew_exp [6] = '{14, 18, 22, 26, 30, 30};

  initial begin
    model_reset();
    do_reset(X + 40, Y + 2);
    scan("post reset");

    // First tick loads directly.
    do_tick(30, 32'h0000_0032, 1);
    probe_exp("first tick p0", X + 200, Y + 5, pal[0]);
    probe_exp("first tick wall", X + 121, Y + 7, WALL);
    scan("first tick");

    // Slew down to 10, then up to 30 in steps of 4.
    for (int k = 0; k < 11; k++) do_tick(5, 32'h0000_000A, 1);
    probe_exp("p0 at 10", X + 41, Y + 3, pal[0]);
    for (int k = 0; k < 6; k++) begin
      do_tick(5, 32'h0000_001E, 1);
      probe_exp($sformatf("slew step %0d", k), X + slew_exp[k] * 4 + 2, Y + 9, pal[0]);
    end
    scan("after slew");

    // Priority and activity.
    for (int k = 0; k < 3; k++) do_tick(40, 32'h0028_0028, 2);
    probe_exp("wall over player", X + 160, Y + 1, WALL);
    do_tick(5, 32'h0028_0028, 2);
    probe_exp("player after wall moves", X + 161, Y + 1, pal[0]);
    do_tick(5, 32'h0028_0014, 2);
    probe_exp("inactive p2 hidden", X + 162, Y + 1, BG);
    scan("priority");
    do_tick(5, 32'h0828_1014, 7);
    scan("num clamp");

    // Blink: p0 held at 60 in the goal window, then at 71 outside it.
    for (int k = 0; k < 36; k++) begin
      do_tick(5, 32'h0000_003C, 1);
      probe($sformatf("blink %0d", k), X + 240 + int'($urandom_range(0, 3)), Y + 4);
    end
    for (int k = 0; k < 20; k++) begin
      do_tick(5, 32'h0000_0047, 1);
      probe($sformatf("no blink %0d", k), X + 284 + int'($urandom_range(0, 3)), Y + 4);
    end

    // Boundaries.
    do_tick(200, 32'h0000_0000, 0);
    for (int k = 0; k < 4; k++) probe_exp($sformatf("wall clamp %0d", k), X + 300 + k, Y + 10, WALL);
    probe_exp("goal lo", X + 200, Y, GOAL);
    probe_exp("goal hi", X + 283, Y + H - 1, GOAL);
    probe_exp("left edge", X - 1, Y + 5, 24'h0);
    probe_exp("right edge", X + W, Y + 5, 24'h0);
    probe_exp("top edge", X + 20, Y - 1, 24'h0);
    probe_exp("bottom edge", X + 20, Y + H, 24'h0);

    // Mid-frame reset during a slew, then a direct load.
    for (int k = 0; k < 20; k++) do_tick(5, 32'h0000_000A, 1);
    do_tick(5, 32'h0000_0046, 1);
    probe_exp("slewing to 70", X + 57, Y + 2, pal[0]);
    do_reset(X + 100, Y + 8);
    scan("after mid reset");
    do_tick(5, 32'h0000_0046, 1);
    probe_exp("direct load 70", X + 281, Y + 2, pal[0]);
    scan("after reload");

    // Randomised frames against the model.
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) begin
        do_tick(int'($urandom_range(0, 255)), $urandom, int'($urandom_range(0, 7)));
      end else begin
        do_tick(int'($urandom_range(0, 80)),
                {8'($urandom_range(40, 80)), 8'($urandom_range(40, 80)),
                 8'($urandom_range(40, 80)), 8'($urandom_range(40, 80))},
                int'($urandom_range(0, 7)));
      end
      scan($sformatf("random %0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
